// File: rtl/preg_release_ctrl_pkg.sv
// Shared types for the physical-register release path: controller states and
// the preg index width that must agree with the free list.
package preg_release_ctrl_pkg;

  localparam int PREG_W = 7;

  typedef enum logic [1:0] {
    NORMAL,
    FLUSH,
    DRAIN
  } state_e;

endpackage

// File: rtl/release_fifo_2w2r.sv
// Circular release buffer with two write and two read lanes. Lane 2 writes only
// alongside lane 1, so writes always land contiguously at tail and tail+1.
module release_fifo_2w2r #(
  parameter int DATA_WIDTH = 7,
  parameter int DEPTH      = 8,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_1_i,
  input  logic [DATA_WIDTH-1:0] wr_data_1_i,
  input  logic                  wr_en_2_i,
  input  logic [DATA_WIDTH-1:0] wr_data_2_i,
  input  logic [1:0]            rd_cnt_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [DATA_WIDTH-1:0] head_next_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [CNT_W-1:0]      free_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, tail_p1, head_p1;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            enq;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    enq     = {1'b0, wr_en_1_i} + {1'b0, wr_en_2_i};
    tail_p1 = tail_q + PTR_W'(1);
    head_p1 = head_q + PTR_W'(1);
    tail_d  = tail_q + PTR_W'(enq);
    head_d  = head_q + PTR_W'(rd_cnt_i);
    count_d = count_q + CNT_W'(enq) - CNT_W'(rd_cnt_i);
  end

  always_ff @(posedge clk) begin
    if (wr_en_1_i) mem_q[tail_q] <= wr_data_1_i;
    if (wr_en_2_i) mem_q[tail_p1] <= wr_data_2_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data_o      = mem_q[head_q];
  assign head_next_data_o = mem_q[head_p1];
  assign count_o          = count_q;
  assign free_o           = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/preg_release_ctrl.sv
// Merges commit and flush-recovery preg releases into the free list push ports,
// giving the flush stream exclusive access and reporting when it has landed.
module preg_release_ctrl
  import preg_release_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = PREG_W,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid_1,
  input  logic [DATA_WIDTH-1:0] commit_preg_1,
  input  logic                  commit_valid_2,
  input  logic [DATA_WIDTH-1:0] commit_preg_2,
  output logic                  commit_ready,
  input  logic                  flush_start,
  input  logic                  flush_valid,
  input  logic [DATA_WIDTH-1:0] flush_preg,
  input  logic                  flush_last,
  output logic                  flush_ready,
  output logic                  flush_done,
  input  logic                  fl_ready,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_2,
  output logic [DATA_WIDTH-1:0] push_data_2
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count, free;
  logic [DATA_WIDTH-1:0] head_data, head_next_data;
  logic                  commit_acc, flush_acc;
  logic                  wr_en_1, wr_en_2;
  logic [DATA_WIDTH-1:0] wr_data_1;
  logic [1:0]            rd_cnt;

  // Readiness depends only on registered state and occupancy. A lone slot-2
  // release is compacted into lane 1 so the buffer never holds a hole.
  always_comb begin
    commit_ready = (state_q == NORMAL) && (free >= CNT_W'(2));
    flush_ready  = (state_q == FLUSH) && (free >= CNT_W'(1));
    commit_acc   = commit_ready && (commit_valid_1 || commit_valid_2);
    flush_acc    = flush_ready && flush_valid;
    wr_en_1      = commit_acc || flush_acc;
    wr_en_2      = commit_acc && commit_valid_1 && commit_valid_2;
    wr_data_1    = flush_acc ? flush_preg : (commit_valid_1 ? commit_preg_1 : commit_preg_2);
  end

  always_comb begin
    push        = fl_ready && (count != '0);
    push_2      = fl_ready && (count >= CNT_W'(2));
    rd_cnt      = {1'b0, push} + {1'b0, push_2};
    push_data   = push ? head_data : '0;
    push_data_2 = push_2 ? head_next_data : '0;
  end

  release_fifo_2w2r #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .wr_en_1_i       (wr_en_1),
    .wr_data_1_i     (wr_data_1),
    .wr_en_2_i       (wr_en_2),
    .wr_data_2_i     (commit_preg_2),
    .rd_cnt_i        (rd_cnt),
    .head_data_o     (head_data),
    .head_next_data_o(head_next_data),
    .count_o         (count),
    .free_o          (free)
  );

  // DRAIN waits for every buffered release, old commits included, to be pushed.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      NORMAL: if (flush_start) state_d = FLUSH;
      FLUSH:  if (flush_acc && flush_last) state_d = DRAIN;
      DRAIN: begin
        if (count == '0) begin
          flush_done = 1'b1;
          state_d    = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= NORMAL;
    else     state_q <= state_d;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(BUF_DEPTH));
  a_push2_push:  assert property (@(posedge clk) disable iff (rst) push_2 |-> push);
  a_push_ready:  assert property (@(posedge clk) disable iff (rst) push |-> fl_ready);

endmodule
